// File: rtl/period_meter_if.sv
// Result port of period_meter: registered period + ovf flag under a valid/ready handshake.
// The producer keeps period and ovf stable for as long as period_valid is high.
interface period_meter_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] period;
   logic             period_valid;
   logic             ovf;
   logic             result_ready;

   modport master (
      output period,
      output period_valid,
      output ovf,
      input  result_ready
   );

   modport slave (
      input  period,
      input  period_valid,
      input  ovf,
      output result_ready
   );
endinterface

// File: rtl/period_meter.sv
// Counts enable ticks between rising edges of sig_in; result registered 1 cycle after the detected edge, held until result_ready.
// A capture arriving while a held result is not being accepted is dropped and flags overrun; PERIOD_METER_SYNC_EN adds a 2-flop sig_in synchronizer.
module period_meter #(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           enable,
   input  logic           sig_in,
   input  logic           start,
   input  logic           stop,
   period_meter_if.master res,
   output logic           overrun,
   output logic           busy
);
   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEAS
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic             ovf_cnt;
   logic [WIDTH-1:0] period_q;
   logic             period_valid_q;
   logic             ovf_q;
   logic             sig_s;
   logic             sig_q;
   logic             rise;
   logic [WIDTH-1:0] cnt_first;
   logic             capture_ok;

`ifdef PERIOD_METER_SYNC_EN
   logic [1:0] sync_ff;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_ff <= 2'b00;
      end else begin
         sync_ff <= {sync_ff[0], sig_in};
      end
   end

   assign sig_s = sync_ff[1];
`else
   assign sig_s = sig_in;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_s;
      end
   end

   assign rise       = sig_s & ~sig_q;
   // The edge cycle itself is the first tick of the next period.
   assign cnt_first  = enable ? CNT_ONE : '0;
   assign capture_ok = !period_valid_q || res.result_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         busy           <= 1'b0;
         cnt            <= '0;
         ovf_cnt        <= 1'b0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         ovf_q          <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         if (period_valid_q && res.result_ready) begin
            period_valid_q <= 1'b0;
         end

         if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            ovf_cnt <= 1'b0;
         end else if (start) begin
            state          <= ARM;
            busy           <= 1'b1;
            cnt            <= '0;
            ovf_cnt        <= 1'b0;
            period_valid_q <= 1'b0;
            ovf_q          <= 1'b0;
            overrun        <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
               end
               ARM: begin
                  if (rise) begin
                     state   <= MEAS;
                     cnt     <= cnt_first;
                     ovf_cnt <= 1'b0;
                  end
               end
               MEAS: begin
                  if (rise) begin
                     // Accepting the held result this cycle frees the slot for the new one.
                     if (capture_ok) begin
                        period_q       <= cnt;
                        ovf_q          <= ovf_cnt;
                        period_valid_q <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                     cnt     <= cnt_first;
                     ovf_cnt <= 1'b0;
                  end else if (enable) begin
                     if (cnt == CNT_MAX) begin
                        ovf_cnt <= 1'b1;
                     end else begin
                        cnt <= cnt + CNT_ONE;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign res.period       = period_q;
   assign res.period_valid = period_valid_q;
   assign res.ovf          = ovf_q;
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the interval between successive rising edges of an input strobe, counted in enable ticks.
- It is the reading end of the tick-timer interface: the timer turns a terminal count into a periodic pulse, and this block turns a periodic pulse back into a count.
- Sits beside the display driver and feeds a measured period (e.g. a button or refresh-rate check) into the digit path through a valid/ready result port.

Parameters:
- WIDTH, 16, width of the period counter and the result.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  count tick; the counter advances only on cycles where enable=1.
- sig_in  input  1  strobe whose rising-edge spacing is measured.
- start  input  1  one-cycle pulse; arms a measurement and clears flags.
- stop  input  1  one-cycle pulse; returns to IDLE.
- result_ready  input  1  consumer accepts the result.
- period  output  WIDTH  last measured period.
- period_valid  output  1  result available; held until accepted.
- ovf  output  1  the held period saturated.
- overrun  output  1  sticky: a result was dropped.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, reset_n=0), all registers clear: state=IDLE, cnt=0, period=0, period_valid=0, ovf=0, overrun=0, busy=0, edge register=0.
- Edge detect: rise = sig_s & ~sig_q, where sig_q is sig_s registered one cycle. sig_s is sig_in, or its synchronized copy (see Optional Feature).
- States and transitions:
  - IDLE: cnt held. start -> ARM.
  - ARM: waits for first rise. rise -> MEAS with cnt <= (enable ? 1 : 0).
  - MEAS: each cycle, enable=1 -> cnt+1, saturating at 2^WIDTH-1 with ovf_cnt set. On rise: the result is captured from cnt and ovf_cnt, cnt <= (enable ? 1 : 0), ovf_cnt cleared, state stays MEAS (back-to-back periods).
- Result value: period = number of enable-high cycles from the starting rise cycle up to, but not including, the ending rise cycle. With enable tied high and rises N cycles apart, period=N.
- Result latency: period and period_valid are registered and appear the cycle after the rise is detected.
- Handshake:
  - period_valid && result_ready clears period_valid on the next edge.
  - While period_valid=1, period and ovf are stable.
- Overrun: a new capture while period_valid=1 and result_ready=0 is dropped (old result kept), and overrun is set.
- Capture and accept in the same cycle: the new result is loaded and period_valid stays 1; no overrun.
- Priority: reset > stop > start > rise.
  - stop in any state -> IDLE. cnt cleared; pending result and flags kept.
  - start in any state -> ARM. cnt=0; period_valid, ovf and overrun cleared.
  - start in the same cycle as a rise: start wins, and the rise is not used as the ARM edge.
- Saturation: cnt never wraps. A saturated capture reports period=2^WIDTH-1 with ovf=1.
- Reset mid-measurement: immediate return to the reset values above. A later start is required.

Optional Feature:
- Macro: PERIOD_METER_SYNC_EN.
- Defined: sig_in passes through a 2-flop synchronizer (both flops reset to 0) before edge detection. Edge-to-result latency becomes 3 cycles from the sig_in transition.
- Undefined: sig_in must be synchronous to clk. Edge-to-result latency is 1 cycle after the registered edge detect.
- Period values are identical in both builds.

Test Plan:
- Basic period: WIDTH=16, enable=1, start, sig_in rises every 10 cycles, result_ready=1 -> period=10, ovf=0, one period_valid pulse per edge from the second edge onward.
- Prescaled ticks: enable high 1 cycle in 4, rises 40 cycles apart -> period=10.
- Saturation: WIDTH=4, enable=1, rises 20 cycles apart -> period=15, ovf=1; next rises 5 apart -> period=5, ovf=0.
- Overrun: result_ready=0, three rises 8 apart -> period=8 (first result) held, overrun=1; assert result_ready -> period_valid drops next cycle; start clears overrun.
- Control: stop mid-MEAS -> busy=0, no further results; start in the same cycle as a rise -> state ARM, no result from that edge.
- Async reset mid-MEAS with period_valid=1 -> all outputs 0 immediately, before the next clk edge. Repeat with PERIOD_METER_SYNC_EN defined and check the 2-cycle extra latency.
